// File: rtl/acc_alu_exec_if.sv
// Control/data bundle between the CPU control FSM (master) and the accumulator execute stage (slave).
interface acc_alu_exec_if #(parameter int DW = 8);
    logic [1:0]    opcode;
    logic          rd;
    logic          load_acc;
    logic          datactl_ena;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_oe;
    logic [DW-1:0] acc;
    logic          zero;
    logic          carry;
    logic          wb_valid;

    modport master (
        output opcode, rd, load_acc, datactl_ena, data_in,
        input  data_out, data_oe, acc, zero, carry, wb_valid
    );

    modport slave (
        input  opcode, rd, load_acc, datactl_ena, data_in,
        output data_out, data_oe, acc, zero, carry, wb_valid
    );
endinterface

// File: rtl/acc_alu_exec.sv
// Accumulator execute stage: INC/DEC/ADD into one accumulator, operand latch, bus write-back.
// Optional macro CARRY_FLAG_EN adds a carry/borrow register; without it carry is tied to 0.
module acc_alu_exec #(
    parameter int            DW       = 8,
    parameter logic [DW-1:0] ACC_INIT = '0
) (
    input  logic          clk1,
    input  logic          rst_n,
    acc_alu_exec_if.slave bus
);
    localparam logic [1:0] OP_JMP = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

`ifdef CARRY_FLAG_EN
    localparam int SW = DW + 1;
`else
    localparam int SW = DW;
`endif

    typedef enum logic [1:0] {S_IDLE, S_OPND, S_EXEC, S_WB} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_opnd;
    logic [DW-1:0] r_data_out;
    logic          r_opnd_vld;
    logic          r_zero;
    logic          r_data_oe;
    logic          r_wb_valid;
    logic          w_capture;
    logic          w_write;
    logic          w_wb_start;
    logic          w_wb_end;
    logic          w_clr_opnd;
    logic [DW-1:0] w_operand;
    logic [SW-1:0] w_sum;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus write-back takes priority so a load_acc/datactl_ena overlap still lands in WB.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.datactl_ena)                         w_state_next = S_WB;
                else if (bus.load_acc)                       w_state_next = S_EXEC;
                else if (bus.rd && (bus.opcode == OP_ADD))   w_state_next = S_OPND;
            end
            S_OPND, S_EXEC: begin
                if (bus.datactl_ena)                         w_state_next = S_WB;
                else if (bus.load_acc)                       w_state_next = S_EXEC;
                else if (!bus.rd)                            w_state_next = S_IDLE;
            end
            S_WB: begin
                if (!bus.datactl_ena)                        w_state_next = S_IDLE;
            end
            default:                                         w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_write    = bus.load_acc && (bus.opcode != OP_JMP);
        w_capture  = ((r_state == S_IDLE) || (r_state == S_OPND)) && bus.rd &&
                     !bus.load_acc && !bus.datactl_ena && (bus.opcode == OP_ADD);
        w_clr_opnd = (w_state_next == S_IDLE);
        w_wb_start = bus.datactl_ena && !r_data_oe;
        w_wb_end   = !bus.datactl_ena && r_data_oe;
    end

    // With the carry build the sum is one bit wider; its MSB is carry-out or borrow.
    always_comb begin
        w_operand = r_opnd_vld ? r_opnd : bus.data_in;
        case (bus.opcode)
            OP_ADD:  w_sum = SW'(r_acc) + SW'(w_operand);
            OP_INC:  w_sum = SW'(r_acc) + SW'(1);
            OP_DEC:  w_sum = SW'(r_acc) - SW'(1);
            default: w_sum = SW'(r_acc);
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= ACC_INIT;
            r_zero     <= (ACC_INIT == '0);
            r_opnd     <= '0;
            r_opnd_vld <= 1'b0;
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
            r_wb_valid <= 1'b0;
        end else begin
            if (w_write) begin
                r_acc  <= w_sum[DW-1:0];
                r_zero <= (w_sum[DW-1:0] == '0);
            end
            if (w_capture) begin
                r_opnd     <= bus.data_in;
                r_opnd_vld <= 1'b1;
            end else if (w_clr_opnd) begin
                r_opnd_vld <= 1'b0;
            end
            r_wb_valid <= w_wb_start;
            if (w_wb_start) begin
                r_data_out <= r_acc;
                r_data_oe  <= 1'b1;
            end else if (w_wb_end) begin
                r_data_oe  <= 1'b0;
            end
        end
    end

`ifdef CARRY_FLAG_EN
    logic r_carry;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (w_write) begin
            r_carry <= w_sum[SW-1];
        end
    end

    assign bus.carry = r_carry;
`else
    assign bus.carry = 1'b0;
`endif

    assign bus.acc      = r_acc;
    assign bus.zero     = r_zero;
    assign bus.data_out = r_data_out;
    assign bus.data_oe  = r_data_oe;
    assign bus.wb_valid = r_wb_valid;
endmodule
